// File: rtl/dst_transpose_buffer.sv
// rtl/dst_transpose_buffer.sv - DST inter-stage round/narrow and 4x4 row-in, column-out transpose buffer
// Optional clamping of out-of-range coefficients is built when DST_SAT_EN is defined.
module dst_transpose_buffer #(
  parameter int IN_W  = 22,
  parameter int MID_W = 16,
  parameter int SHIFT = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_row [0:3],
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [MID_W-1:0] out_col [0:3],
  output logic [1:0]              out_col_idx,
  output logic                    out_last,
  output logic                    out_sat
);

  typedef enum logic {FILL, DRAIN} state_t;

  localparam logic signed [IN_W:0] RND   = (IN_W+1)'(2**(SHIFT-1));
  localparam logic signed [IN_W:0] Y_MAX = (IN_W+1)'(2**(MID_W-1) - 1);
  localparam logic signed [IN_W:0] Y_MIN = (IN_W+1)'(-(2**(MID_W-1)));

  state_t state_q, state_d;
  logic [1:0] row_q, row_d;
  logic [1:0] col_q, col_d;
  logic       in_ready_q, in_ready_d;
  logic signed [MID_W-1:0] buf_q [0:3][0:3];
  logic signed [MID_W-1:0] buf_d [0:3][0:3];

  logic signed [IN_W:0]    y_sum  [0:3];
  logic signed [IN_W:0]    y_full [0:3];
  logic signed [MID_W-1:0] y_mid  [0:3];

`ifdef DST_SAT_EN
  logic y_sat [0:3];
  logic sat_q [0:3][0:3];
  logic sat_d [0:3][0:3];
`else
  logic [IN_W-MID_W:0] y_hi_unused [0:3];
`endif

  logic accept_in, accept_out;

  assign accept_in  = (state_q == FILL) && in_valid && in_ready_q;
  assign accept_out = (state_q == DRAIN) && out_ready;

  // Round half up at IN_W+1 bits so the rounding constant cannot overflow.
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      y_sum[c]  = {in_row[c][IN_W-1], in_row[c]} + RND;
      y_full[c] = y_sum[c] >>> SHIFT;
`ifdef DST_SAT_EN
      y_sat[c] = 1'b0;
      if (y_full[c] > Y_MAX) begin
        y_mid[c] = Y_MAX[MID_W-1:0];
        y_sat[c] = 1'b1;
      end else if (y_full[c] < Y_MIN) begin
        y_mid[c] = Y_MIN[MID_W-1:0];
        y_sat[c] = 1'b1;
      end else begin
        y_mid[c] = y_full[c][MID_W-1:0];
      end
`else
      y_mid[c]       = y_full[c][MID_W-1:0];
      y_hi_unused[c] = y_full[c][IN_W:MID_W];
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    buf_d   = buf_q;
`ifdef DST_SAT_EN
    sat_d   = sat_q;
`endif
    case (state_q)
      FILL: begin
        if (accept_in) begin
          for (int c = 0; c < 4; c++) begin
            buf_d[row_q][c] = y_mid[c];
`ifdef DST_SAT_EN
            sat_d[row_q][c] = y_sat[c];
`endif
          end
          row_d = row_q + 2'd1;
          if (row_q == 2'd3) begin
            state_d = DRAIN;
            col_d   = 2'd0;
          end
        end
      end
      DRAIN: begin
        if (accept_out) begin
          col_d = col_q + 2'd1;
          if (col_q == 2'd3) begin
            state_d = FILL;
            row_d   = 2'd0;
          end
        end
      end
      default: state_d = FILL;
    endcase
    in_ready_d = (state_d == FILL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FILL;
      row_q      <= 2'd0;
      col_q      <= 2'd0;
      in_ready_q <= 1'b0;
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          buf_q[r][c] <= '0;
`ifdef DST_SAT_EN
          sat_q[r][c] <= 1'b0;
`endif
        end
      end
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      in_ready_q <= in_ready_d;
      buf_q      <= buf_d;
`ifdef DST_SAT_EN
      sat_q      <= sat_d;
`endif
    end
  end

  // Outputs are a column mux over the buffer, qualified by the DRAIN state.
  always_comb begin
    out_valid   = (state_q == DRAIN);
    out_col_idx = col_q;
    out_last    = out_valid && (col_q == 2'd3);
    out_sat     = 1'b0;
    for (int r = 0; r < 4; r++) begin
      out_col[r] = out_valid ? buf_q[r][col_q] : '0;
`ifdef DST_SAT_EN
      out_sat = out_sat | (out_valid & sat_q[r][col_q]);
`endif
    end
  end

  assign in_ready = in_ready_q;

endmodule
